// File: rtl/led_frame_packer_pkg.sv
// Shared types and helpers for the LED frame packer.
// Word layout: {header, brightness, B, G, R}.
package led_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    HOLD    = 2'd2
  } packer_state_t;

  localparam logic [2:0]  LED_HDR      = 3'b111;
  localparam logic [31:0] LED_OFF_WORD = 32'hE000_0000;

  function automatic logic [31:0] led_word(input logic [4:0] bright,
                                           input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {LED_HDR, bright, b, g, r};
  endfunction

endpackage

// File: rtl/led_frame_packer_if.sv
// Pixel stream handshake between an upstream source and the LED frame packer.
interface led_frame_packer_if;

  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_last;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);

endinterface

// File: rtl/led_frame_packer.sv
// Packs an RGB pixel stream into a parallel LED image for the serial sender,
// then holds off new pixels while the sender transmits.
//
// state   | meaning
// COLLECT | accept pixels into the build register
// ISSUE   | one-cycle enable pulse, data_out freshly loaded
// HOLD    | down-count hold-off window, no pixels accepted
module led_frame_packer
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int HOLD_CYCLES = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  led_frame_packer_if.slave      pix,
  input  logic [4:0]             bright,
  output logic [LED_NUM*32-1:0]  data_out,
  output logic                   enable,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int SLOT_W = $clog2(LED_NUM);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LED_NUM - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  packer_state_t          state_q, state_d;
  logic [SLOT_W-1:0]      slot_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [4:0]             bright_lat;
  logic [LED_NUM*32-1:0]  build_q, build_d;

  logic        accept, last_slot, done, err;
  logic [4:0]  cur_bright;
  logic [31:0] cur_word;

  assign pix.pix_ready = (state_q == COLLECT) && !rst;
  assign busy          = (state_q == ISSUE) || (state_q == HOLD);

  assign accept    = pix.pix_valid && pix.pix_ready;
  assign last_slot = (slot_q == LAST_SLOT);
  assign done      = accept && (pix.pix_last || last_slot);
  // short image (last too early) or overlong image (no last on final slot)
  assign err       = accept && (pix.pix_last ^ last_slot);

  assign cur_bright = (slot_q == '0) ? bright : bright_lat;
  assign cur_word   = led_word(cur_bright, pix.pix_data[23:16],
                               pix.pix_data[15:8], pix.pix_data[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (done) state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (hold_q == '0) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Slot 0 lives in the most significant word; a short image fills the tail with LED-off.
  always_comb begin
    build_d = build_q;
    if (accept) begin
      for (int i = 0; i < LED_NUM; i++) begin
        if (i == int'(slot_q))
          build_d[(LED_NUM-i)*32-1 -: 32] = cur_word;
        else if (pix.pix_last && (i > int'(slot_q)))
          build_d[(LED_NUM-i)*32-1 -: 32] = LED_OFF_WORD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      build_q    <= '0;
      data_out   <= '0;
      slot_q     <= '0;
      hold_q     <= '0;
      bright_lat <= '0;
      enable     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      build_q   <= build_d;
      enable    <= done;
      frame_err <= err;
      if (done) begin
        data_out <= build_d;
        slot_q   <= '0;
      end else if (accept) begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      if (accept && (slot_q == '0))
        bright_lat <= bright;
      if (state_q == ISSUE)
        hold_q <= HOLD_LOAD;
      else if ((state_q == HOLD) && (hold_q != '0))
        hold_q <= hold_q - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_led_frame_packer.sv
// Directed bench for led_frame_packer with LED_NUM=4, HOLD_CYCLES=16.
module tb_led_frame_packer;
  import led_pkg::*;

  localparam int LED_NUM     = 4;
  localparam int HOLD_CYCLES = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [4:0]            bright = '0;
  logic [LED_NUM*32-1:0] data_out;
  logic                  enable, frame_err, busy;

  led_frame_packer_if pix();

  led_frame_packer #(.LED_NUM(LED_NUM), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix       (pix),
    .bright    (bright),
    .data_out  (data_out),
    .enable    (enable),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!pix.pix_ready && n < 100) begin
      step();
      n++;
    end
    if (!pix.pix_ready) chk(tag, 128'(n), 128'(0));
  endtask

  task automatic push(input logic [23:0] d, input logic l);
    pix.pix_valid = 1'b1;
    pix.pix_data  = d;
    pix.pix_last  = l;
    wait_ready("push_timeout");
    step();
    pix.pix_valid = 1'b0;
    pix.pix_last  = 1'b0;
  endtask

  localparam logic [127:0] IMG_NORMAL = {32'hFF332211, 32'hFF665544, 32'hFF998877, 32'hFFCCBBAA};
  localparam logic [127:0] IMG_DIM    = {32'hE3332211, 32'hE3665544, 32'hE3998877, 32'hE3CCBBAA};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0]  pix_tab [8];
    logic [127:0] img [2];
    int           en_cyc [2];
    int           k, cyc, n_en, lo_cnt, stable_bad, en_cnt;
    logic         rdy;

    pix.pix_valid = 1'b0;
    pix.pix_data  = '0;
    pix.pix_last  = 1'b0;

    // reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_pix_ready", 128'(pix.pix_ready), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_enable", 128'(enable), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(pix.pix_ready), 128'(1));

    // normal image
    bright = 5'h1F;
    push(24'h112233, 1'b0);
    push(24'h445566, 1'b0);
    push(24'h778899, 1'b0);
    push(24'hAABBCC, 1'b1);
    chk("norm_enable", 128'(enable), 128'(1));
    chk("norm_frame_err", 128'(frame_err), 128'(0));
    chk("norm_data", data_out, IMG_NORMAL);
    chk("norm_busy", 128'(busy), 128'(1));
    chk("norm_ready", 128'(pix.pix_ready), 128'(0));
    step();
    chk("norm_enable_1cyc", 128'(enable), 128'(0));
    chk("norm_hold_busy", 128'(busy), 128'(1));

    // short image
    bright = 5'h01;
    push(24'hFF0000, 1'b0);
    push(24'h00FF00, 1'b1);
    chk("short_enable", 128'(enable), 128'(1));
    chk("short_frame_err", 128'(frame_err), 128'(1));
    chk("short_data", data_out, {32'hE10000FF, 32'hE100FF00, 32'hE0000000, 32'hE0000000});
    step();
    chk("short_err_1cyc", 128'(frame_err), 128'(0));

    // overlong image, then the 5th pixel starts a fresh image
    bright = 5'h1F;
    push(24'h000001, 1'b0);
    push(24'h000002, 1'b0);
    push(24'h000003, 1'b0);
    push(24'h000004, 1'b0);
    chk("long_enable", 128'(enable), 128'(1));
    chk("long_frame_err", 128'(frame_err), 128'(1));
    chk("long_data", data_out, {32'hFF010000, 32'hFF020000, 32'hFF030000, 32'hFF040000});
    push(24'h0A0B0C, 1'b0);
    push(24'h102030, 1'b0);
    push(24'h405060, 1'b0);
    push(24'h708090, 1'b1);
    chk("realign_enable", 128'(enable), 128'(1));
    chk("realign_frame_err", 128'(frame_err), 128'(0));
    chk("realign_data", data_out, {32'hFF0C0B0A, 32'hFF302010, 32'hFF605040, 32'hFF908070});

    // continuous stream: hold-off timing and brightness latch
    wait_ready("stream_start_timeout");
    pix_tab = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC,
                24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    img        = '{128'(0), 128'(0)};
    en_cyc     = '{0, 0};
    bright     = 5'h1F;
    k = 0; cyc = 0; n_en = 0; lo_cnt = 0; stable_bad = 0;
    pix.pix_valid = 1'b1;
    while ((k < 8 || n_en < 2) && cyc < 300) begin
      if (k < 8) begin
        pix.pix_data = pix_tab[k];
        pix.pix_last = (k == 3) || (k == 7);
      end
      rdy = pix.pix_ready && pix.pix_valid;
      step();
      cyc++;
      if (rdy) begin
        k++;
        if (k == 2) bright = 5'h03;
        if (k == 8) begin
          pix.pix_valid = 1'b0;
          pix.pix_last  = 1'b0;
        end
      end
      if (enable && n_en < 2) begin
        en_cyc[n_en] = cyc;
        img[n_en]    = data_out;
        n_en++;
      end else if (n_en == 1 && data_out !== img[0]) begin
        stable_bad++;
      end
      if (n_en == 1 && !pix.pix_ready) lo_cnt++;
    end
    chk("stream_enables", 128'(n_en), 128'(2));
    chk("stream_ready_low", 128'(lo_cnt), 128'(HOLD_CYCLES + 1));
    chk("stream_spacing", 128'(en_cyc[1] - en_cyc[0]), 128'(LED_NUM + 1 + HOLD_CYCLES));
    chk("stream_stable", 128'(stable_bad), 128'(0));
    chk("bright_img0", img[0], IMG_NORMAL);
    chk("bright_img1", img[1], IMG_DIM);

    // reset mid-image
    bright = 5'h1F;
    wait_ready("midrst_start_timeout");
    push(24'h010203, 1'b0);
    push(24'h040506, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_data_async", data_out, 128'(0));
    chk("midrst_ready", 128'(pix.pix_ready), 128'(0));
    step();
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 128'(pix.pix_ready), 128'(1));
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (enable) en_cnt++;
      step();
    end
    chk("midrst_no_enable", 128'(en_cnt), 128'(0));
    chk("midrst_data_zero", data_out, 128'(0));
    push(24'h112233, 1'b0);
    push(24'h445566, 1'b0);
    push(24'h778899, 1'b0);
    push(24'hAABBCC, 1'b1);
    chk("midrst_next_enable", 128'(enable), 128'(1));
    chk("midrst_next_data", data_out, IMG_NORMAL);
    chk("midrst_next_err", 128'(frame_err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_packer.md
# led_frame_packer

Upstream feeder for the LED serial sender. It accepts a per-pixel RGB stream over a valid/ready handshake and formats each pixel into a 32-bit LED word: 3'b111, 5-bit brightness, blue, green, red. It collects LED_NUM words into one parallel image and hands that image to the sender's `data_in`/`enable` pair. After each hand-off it enforces a hold-off window so the sender can finish transmitting before the next image is issued.

## Interface
- `LED_NUM`, 4: LED words per image; legal range 2..32; `data_out` width is LED_NUM*32.
- `HOLD_CYCLES`, 2048: clk cycles after an `enable` pulse before the next pixel is accepted; legal range ≥ 1. Must cover the sender's full transmission: (LED_NUM+2)*32 bits × 10 clk plus wait time.
- `clk` in 1: 150 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `pix_valid` in 1: pixel present.
- `pix_ready` out 1: the packer accepts a pixel this cycle.
- `pix_data` in 24: R[23:16], G[15:8], B[7:0].
- `pix_last` in 1: marks the final pixel of an image.
- `bright` in 5: global brightness; sampled with the first pixel of each image.
- `data_out` out LED_NUM*32: packed image; connects to the sender's `data_in`.
- `enable` out 1: one-cycle start pulse to the sender.
- `frame_err` out 1: one-cycle pulse when `pix_last` disagrees with the slot count.
- `busy` out 1: high in ISSUE and HOLD.

## Operation
- **States:** COLLECT, ISSUE, HOLD. Reset enters COLLECT.
- **COLLECT**
  - `pix_ready` = 1.
  - A pixel is accepted when `pix_valid` && `pix_ready`.
  - Accepted pixel k (k = 0..LED_NUM-1) is written to word slot `data_out[(LED_NUM-k)*32-1 -: 32]`, so slot 0 is the most significant word and is transmitted first.
  - Word format: {3'b111, bright_lat, B, G, R}.
  - `bright_lat` is captured from `bright` on k = 0 and held for the whole image.
- **Normal completion:** pixel k = LED_NUM-1 accepted with `pix_last` = 1 → go to ISSUE.
- **Overlong image:** pixel k = LED_NUM-1 accepted with `pix_last` = 0 → `frame_err` pulse, go to ISSUE.
  - The pixel stream is not realigned. The next accepted pixel starts a new image at k = 0.
- **Short image:** `pix_last` = 1 on an accepted pixel with k < LED_NUM-1.
  - Slots k+1..LED_NUM-1 are filled with 32'hE000_0000 (LED off).
  - `frame_err` pulses, then go to ISSUE.
- **ISSUE:** `enable` = 1 for exactly one cycle, `pix_ready` = 0, then go to HOLD with the hold counter loaded to HOLD_CYCLES-1.
- **HOLD:** `pix_ready` = 0; the counter decrements each cycle; on 0 go to COLLECT.
- **Build buffer:** the image is assembled in a build register.
  - `data_out` is a separate register, loaded from the build register (including fill) on the cycle the state enters ISSUE.
  - `data_out` is held unchanged until the next ISSUE. The sender therefore sees stable data through its whole transmission.
- `bright` changes mid-image have no effect until the next image.

## Timing
- **Reset values:**
  - `data_out` = 0, `enable` = 0, `frame_err` = 0, `busy` = 0.
  - `pix_ready` = 0 while `rst` is high.
  - Slot index = 0, hold counter = 0, `bright_lat` = 0.
- First cycle after `rst` deasserts: `pix_ready` = 1.
- **Outputs:** `pix_ready` and `busy` decode directly from the state register; all other outputs are registered.
- **Latency:**
  - The completing pixel is accepted on the edge ending cycle N.
  - Cycle N+1: `enable` = 1, `data_out` valid, `frame_err` (if any) = 1.
  - Cycle N+2 through N+1+HOLD_CYCLES: HOLD.
  - Cycle N+2+HOLD_CYCLES: `pix_ready` = 1.
- Minimum `enable` spacing is LED_NUM+1+HOLD_CYCLES cycles.
- `pix_valid` while `pix_ready` = 0: nothing is consumed; the upstream source must hold its data.
- **Widths:**
  - Slot index: $clog2(LED_NUM) bits; no wrap past LED_NUM-1, it resets to 0 on ISSUE.
  - Hold counter: $clog2(HOLD_CYCLES) bits, minimum 1.
- **Reset mid-operation:** `rst` in any state immediately returns to COLLECT and clears `data_out`. A partial image is discarded and no `enable` is emitted.

## Structure
- Package `led_pkg` holds:
  - the `packer_state_t` enum (COLLECT, ISSUE, HOLD);
  - `LED_HDR` = 3'b111;
  - `LED_OFF_WORD` = 32'hE000_0000;
  - the function `led_word(bright, r, g, b)`.
- No sub-module: a single always_ff state register, one combinational next-state block, and datapath registers.

## Test plan
- **Normal image:** LED_NUM=4, `bright`=5'h1F, pixels 0x112233, 0x445566, 0x778899, 0xAABBCC with `pix_last` on the 4th → `enable` one cycle after the 4th accept; `data_out` = {FF332211, FF665544, FF998877, FFCCBBAA}; `frame_err` = 0.
- **Short image:** 2 pixels 0xFF0000, 0x00FF00 with `pix_last` on the 2nd, `bright`=5'h01 → `data_out` = {E10000FF, E100FF00, E0000000, E0000000}; `frame_err` pulses together with `enable`.
- **Overlong image:** 4 pixels without `pix_last` → `frame_err` = 1 and `enable` = 1 in the same cycle; the 5th pixel becomes slot 0 of the next image.
- **Hold-off:** HOLD_CYCLES=16, `pix_valid` held high continuously → `pix_ready` low for exactly 17 cycles after the completing accept; `enable` spacing = 21 cycles; `data_out` constant between pulses.
- **Brightness latch:** `bright` changes from 5'h1F to 5'h03 after pixel 1 → all 4 words of that image carry 5'h1F; the next image carries 5'h03.
- **Reset mid-image:** `rst` pulsed after 2 pixels → no `enable`; `data_out` = 0; `pix_ready` = 1 the cycle after release; the next full image packs correctly starting at slot 0.
